// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL / DIVU / REMU sequencer that borrows the core's shared add/sub ALU.
// Restoring division keeps a 33-bit partial remainder: the 32-bit register plus its shifted-out MSB.
module alu_muldiv_seq #(
    parameter int unsigned D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] result,
    output logic [D_WIDTH-1:0] alu_op1,
    output logic [D_WIDTH-1:0] alu_op2,
    output logic [2:0]         alu_ctrl,
    input  logic [D_WIDTH-1:0] alu_out
);

    localparam int unsigned CW = $clog2(D_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // acc_q: product accumulator (MUL) or partial remainder (DIV)
    // sh_q : shifted multiplicand (MUL) or dividend/quotient (DIV)
    // rt_q : shifting multiplier (MUL) or constant divisor (DIV)
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [D_WIDTH-1:0] acc_q, acc_d;
    logic [D_WIDTH-1:0] sh_q, sh_d;
    logic [D_WIDTH-1:0] rt_q, rt_d;
    logic [D_WIDTH-1:0] result_d;
    logic               busy_d, done_d;

    logic [D_WIDTH-1:0] rs;
    logic               borrow, ge;

    // Next-state, datapath update and ALU drive
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        rt_d     = rt_q;
        result_d = result;
        alu_op1  = '0;
        alu_op2  = '0;
        alu_ctrl = 3'd0;

        rs     = {acc_q[D_WIDTH-2:0], sh_q[D_WIDTH-1]};
        borrow = (~rs[D_WIDTH-1] & rt_q[D_WIDTH-1]) |
                 (~(rs[D_WIDTH-1] ^ rt_q[D_WIDTH-1]) & alu_out[D_WIDTH-1]);
        ge     = acc_q[D_WIDTH-1] | ~borrow;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    acc_d = '0;
                    sh_d  = a;
                    rt_d  = b;
                    if (op[1] && (b == '0)) begin
                        state_d  = S_DONE;
                        result_d = op[0] ? a : '1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!op_q[1]) begin
                    alu_op1 = acc_q;
                    alu_op2 = rt_q[0] ? sh_q : '0;
                    acc_d   = alu_out;
                    sh_d    = sh_q << 1;
                    rt_d    = rt_q >> 1;
                end else begin
                    alu_ctrl = 3'd1;
                    alu_op1  = rs;
                    alu_op2  = rt_q;
                    acc_d    = ge ? alu_out : rs;
                    sh_d     = {sh_q[D_WIDTH-2:0], ge};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(D_WIDTH - 1)) begin
                    state_d = S_DONE;
                    if (!op_q[1])    result_d = acc_d;
                    else if (op_q[0]) result_d = acc_d;
                    else              result_d = sh_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            rt_q    <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            rt_q    <= rt_d;
            result  <= result_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: shared ALU model, cycle-level reference model and directed/random ops.
module tb_alu_muldiv_seq;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result, alu_op1, alu_op2, alu_out;
    logic [2:0]   alu_ctrl;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alu_muldiv_seq #(.D_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
    );

    // Shared add/sub ALU the sequencer borrows
    assign alu_out = (alu_ctrl == 3'd1) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (!o[1]) return x * y;
        if (y == '0) return o[0] ? x : '1;
        return o[0] ? (x % y) : (x / y);
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] y);
        return (o[1] && (y == '0)) ? 1 : int'(LAT);
    endfunction

    // Reference model: transaction-level busy window and result timing
    bit           m_busy = 1'b0;
    bit           m_div  = 1'b0;
    int           m_cnt  = 0;
    int           m_lat  = 0;
    logic [W-1:0] m_res  = '0;
    logic [W-1:0] m_pend = '0;
    logic         m_done;
    assign m_done = m_busy && (m_cnt == m_lat);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_lat  <= 0;
            m_res  <= '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_div  <= op[1];
                m_cnt  <= 1;
                m_lat  <= lat_of(op, b);
                m_pend <= calc(op, a, b);
                if (lat_of(op, b) == 1) m_res <= calc(op, a, b);
            end
        end else if (m_cnt == m_lat) begin
            m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) m_res <= m_pend;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", W'(busy), W'(m_busy));
            check("done", W'(done), W'(m_done));
            check("result", result, m_res);
            if (m_busy && !m_done) begin
                check("alu_ctrl_run", W'(alu_ctrl), m_div ? W'(1) : W'(0));
            end else begin
                check("alu_ctrl_idle", W'(alu_ctrl), W'(0));
                check("alu_op1_idle", alu_op1, W'(0));
                check("alu_op2_idle", alu_op2, W'(0));
            end
        end
    end

    // Issue one op, measure accept-to-done latency, optionally spray ignored starts
    task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp, input int exp_lat,
                         input bit noise);
        int k;
        logic [W-1:0] res_at_done;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (!done && k < 60) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk); #1;
            k++;
        end
        res_at_done = result;
        start = noise;
        a = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " latency"}, W'(k), W'(exp_lat));
        check({name, " result"}, res_at_done, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #1;
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst result", result, W'(0));
        check("rst alu_op1", alu_op1, W'(0));
        check("rst alu_op2", alu_op2, W'(0));
        check("rst alu_ctrl", W'(alu_ctrl), W'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        do_op("mul 7*6",        2'b00, 32'd7,          32'd6,          32'd42,         33, 1'b0);
        do_op("mul ff*ff",      2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33, 1'b0);
        do_op("mul 2^16*2^16",  2'b00, 32'h00010000,   32'h00010000,   32'h0,          33, 1'b0);
        do_op("divu 100/7",     2'b10, 32'd100,        32'd7,          32'd14,         33, 1'b0);
        do_op("remu 100/7",     2'b11, 32'd100,        32'd7,          32'd2,          33, 1'b0);
        do_op("divu max/1",     2'b10, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33, 1'b0);
        do_op("divu msb/max",   2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h0,          33, 1'b0);
        do_op("remu msb/max",   2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33, 1'b0);
        do_op("divu 5/0",       2'b10, 32'd5,          32'd0,          32'hFFFFFFFF,   1,  1'b0);
        do_op("remu 5/0",       2'b11, 32'd5,          32'd0,          32'd5,          1,  1'b0);
        do_op("mul noisy",      2'b00, 32'd123,        32'd456,        32'd56088,      33, 1'b1);
        do_op("divu back2back", 2'b10, 32'd1000,       32'd10,         32'd100,        33, 1'b0);

        // Async reset in the middle of a multiply (cnt=10)
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrun rst busy", W'(busy), W'(0));
        check("midrun rst done", W'(done), W'(0));
        check("midrun rst result", result, W'(0));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_op("remu after rst", 2'b11, 32'd1000, 32'd7, 32'd6, 33, 1'b0);

        // Randomized ops against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = ra;
                default: rb = $urandom;
            endcase
            do_op("random", ro, ra, rb, calc(ro, ra, rb), lat_of(ro, rb), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Run-away guard
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1);
    end

endmodule
